// File: rtl/pio_fifo_pair.sv
// Pair of show-ahead FIFOs (TX and RX) sharing one 2*DEPTH-entry array.
// join_mode lets either direction borrow the other's half of the storage.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       join_mode,
  input  logic             flush,
  input  logic             err_clr,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  input  logic             tx_pull,
  output logic [WIDTH-1:0] tx_dout,
  output logic             tx_full,
  output logic             tx_empty,
  output logic [LW-1:0]    tx_level,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_din,
  input  logic             rx_pull,
  output logic [WIDTH-1:0] rx_dout,
  output logic             rx_full,
  output logic             rx_empty,
  output logic [LW-1:0]    rx_level,
  output logic             tx_over,
  output logic             rx_over,
  output logic             tx_under,
  output logic             rx_under
);

  localparam int AW = $clog2(2*DEPTH);
  localparam logic [LW-1:0] CAP_D  = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_2D = LW'(2*DEPTH);

  typedef enum logic [1:0] {
    MODE_SEP     = 2'b00,
    MODE_JOIN_TX = 2'b01,
    MODE_JOIN_RX = 2'b10
  } mode_t;

  mode_t            mode_q, mode_n;
  logic             mode_chg, clear;
  logic [WIDTH-1:0] mem [2*DEPTH];

  // Index 0 is TX, index 1 is RX throughout.
  logic [AW-1:0]    rptr [2], wptr [2], rptr_nx [2], wptr_nx [2];
  logic [AW-1:0]    base [2], raddr [2], waddr [2];
  logic [LW-1:0]    lvl [2], cap [2];
  logic [WIDTH-1:0] din [2], dout [2];
  logic [1:0]       push, pull, full, empty, do_push, do_pull;
  logic [1:0]       over_ev, under_ev, over_q, under_q;

  assign push   = {rx_push, tx_push};
  assign pull   = {rx_pull, tx_pull};
  assign din[0] = tx_din;
  assign din[1] = rx_din;

  // 2'b11 folds onto separate mode, so 00<->11 is not a mode change.
  assign mode_n   = (join_mode == 2'b11) ? MODE_SEP : mode_t'(join_mode);
  assign mode_chg = (mode_n != mode_q);
  assign clear    = flush | mode_chg;

  always_comb begin
    cap[0]  = CAP_D;
    cap[1]  = CAP_D;
    base[0] = '0;
    base[1] = AW'(DEPTH);
    case (mode_q)
      MODE_JOIN_TX: begin
        cap[0]  = CAP_2D;
        cap[1]  = '0;
        base[1] = '0;
      end
      MODE_JOIN_RX: begin
        cap[0]  = '0;
        cap[1]  = CAP_2D;
        base[1] = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]     = (lvl[i] == cap[i]);
      empty[i]    = (lvl[i] == '0);
      do_pull[i]  = pull[i] & ~empty[i] & ~clear;
      // A pull in the same cycle frees the slot a push into a full FIFO needs.
      do_push[i]  = push[i] & (~full[i] | do_pull[i]) & ~clear;
      over_ev[i]  = push[i] & ~do_push[i] & ~clear;
      under_ev[i] = pull[i] & empty[i] & ~clear;
      rptr_nx[i]  = (LW'(rptr[i]) + LW'(1) == cap[i]) ? '0 : rptr[i] + AW'(1);
      wptr_nx[i]  = (LW'(wptr[i]) + LW'(1) == cap[i]) ? '0 : wptr[i] + AW'(1);
      raddr[i]    = base[i] + rptr[i];
      waddr[i]    = base[i] + wptr[i];
      dout[i]     = empty[i] ? '0 : mem[raddr[i]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_SEP;
      for (int unsigned i = 0; i < 2; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        lvl[i]  <= '0;
      end
      over_q  <= '0;
      under_q <= '0;
    end else begin
      mode_q <= mode_n;
      for (int unsigned i = 0; i < 2; i++) begin
        if (clear) begin
          rptr[i] <= '0;
          wptr[i] <= '0;
          lvl[i]  <= '0;
        end else begin
          if (do_push[i]) wptr[i] <= wptr_nx[i];
          if (do_pull[i]) rptr[i] <= rptr_nx[i];
          lvl[i] <= lvl[i] + LW'(do_push[i]) - LW'(do_pull[i]);
        end
      end
      over_q  <= (over_q  & ~{2{err_clr}}) | over_ev;
      under_q <= (under_q & ~{2{err_clr}}) | under_ev;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++)
      if (do_push[i]) mem[waddr[i]] <= din[i];
  end

  assign tx_dout  = dout[0];
  assign rx_dout  = dout[1];
  assign tx_full  = full[0];
  assign rx_full  = full[1];
  assign tx_empty = empty[0];
  assign rx_empty = empty[1];
  assign tx_level = lvl[0];
  assign rx_level = lvl[1];
  assign tx_over  = over_q[0];
  assign rx_over  = over_q[1];
  assign tx_under = under_q[0];
  assign rx_under = under_q[1];

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed bench for pio_fifo_pair (WIDTH=32, DEPTH=4) with hand-computed expectations.
module tb_pio_fifo_pair;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  join_mode = 2'b00;
  logic        flush = 1'b0, err_clr = 1'b0;
  logic        tx_push = 1'b0, tx_pull = 1'b0, rx_push = 1'b0, rx_pull = 1'b0;
  logic [31:0] tx_din = '0, rx_din = '0;
  logic [31:0] tx_dout, rx_dout;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [3:0]  tx_level, rx_level;
  logic        tx_over, rx_over, tx_under, rx_under;

  int checks = 0;
  int errors = 0;

  pio_fifo_pair #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .join_mode(join_mode), .flush(flush), .err_clr(err_clr),
    .tx_push(tx_push), .tx_din(tx_din), .tx_pull(tx_pull), .tx_dout(tx_dout),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
    .rx_push(rx_push), .rx_din(rx_din), .rx_pull(rx_pull), .rx_dout(rx_dout),
    .rx_full(rx_full), .rx_empty(rx_empty), .rx_level(rx_level),
    .tx_over(tx_over), .rx_over(rx_over), .tx_under(tx_under), .rx_under(rx_under)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tx_push = 1'b0; tx_pull = 1'b0; rx_push = 1'b0; rx_pull = 1'b0;
    flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tx_wr(input logic [31:0] d);
    tx_push = 1'b1; tx_din = d; step();
  endtask

  task automatic rx_wr(input logic [31:0] d);
    rx_push = 1'b1; rx_din = d; step();
  endtask

  logic [31:0] exp_q [4];

  initial begin
    #2;
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_levels",   {tx_level, rx_level}, 32'd0);
    check("rst_dout",     tx_dout | rx_dout, 32'd0);
    check("rst_flags",    {tx_over, rx_over, tx_under, rx_under}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Fill TX to overflow in separate mode
    tx_wr(32'h11); tx_wr(32'h22); tx_wr(32'h33);
    check("tx_full_at3", 32'(tx_full), 32'd0);
    check("tx_level_3",  32'(tx_level), 32'd3);
    tx_wr(32'h44);
    check("tx_full_at4", 32'(tx_full), 32'd1);
    tx_wr(32'h55);
    check("tx_over",     32'(tx_over), 32'd1);
    check("tx_level_4",  32'(tx_level), 32'd4);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int k = 0; k < 4; k++) begin
      check("tx_pop_order", tx_dout, exp_q[k]);
      tx_pull = 1'b1; step();
    end
    check("tx_empty_after", 32'(tx_empty), 32'd1);
    check("tx_dout_empty",  tx_dout, 32'd0);
    tx_pull = 1'b1; step();
    check("tx_under", 32'(tx_under), 32'd1);

    // err_clr together with a fresh underflow keeps that flag
    err_clr = 1'b1; tx_pull = 1'b1; step();
    check("errclr_keep_under", 32'(tx_under), 32'd1);
    check("errclr_over_clr",   32'(tx_over),  32'd0);
    err_clr = 1'b1; step();
    check("errclr_under_clr",  32'(tx_under), 32'd0);

    // Push and pull together while full
    tx_wr(32'hA1); tx_wr(32'hA2); tx_wr(32'hA3); tx_wr(32'hA4);
    tx_push = 1'b1; tx_din = 32'h99; tx_pull = 1'b1; step();
    check("full_pp_level", 32'(tx_level), 32'd4);
    check("full_pp_over",  32'(tx_over),  32'd0);
    exp_q = '{32'hA2, 32'hA3, 32'hA4, 32'h99};
    for (int k = 0; k < 4; k++) begin
      check("full_pp_order", tx_dout, exp_q[k]);
      tx_pull = 1'b1; step();
    end

    // Push and pull together while RX empty
    rx_push = 1'b1; rx_din = 32'hAB; rx_pull = 1'b1; step();
    check("empty_pp_under", 32'(rx_under), 32'd1);
    check("empty_pp_level", 32'(rx_level), 32'd1);
    check("empty_pp_dout",  rx_dout, 32'hAB);
    check("rx_sep_tx_dout", tx_dout, 32'd0);
    rx_pull = 1'b1; err_clr = 1'b1; step();

    // Mode change 00 -> 10 with TX holding data; strobes in that cycle discarded
    tx_wr(32'h1); tx_wr(32'h2); tx_wr(32'h3);
    join_mode = 2'b10; tx_push = 1'b1; tx_din = 32'h7; step();
    check("chg_levels", {tx_level, rx_level}, 32'd0);
    check("chg_tx_cap0", {tx_full, tx_empty}, 32'b11);
    check("chg_flags",  {tx_over, rx_over, tx_under, rx_under}, 32'd0);
    tx_push = 1'b1; step();
    check("cap0_push_over", 32'(tx_over), 32'd1);
    for (int k = 1; k <= 7; k++) rx_wr(32'h100 + 32'(k));
    check("rxj_full_at7", 32'(rx_full), 32'd0);
    rx_wr(32'h108);
    check("rxj_full_at8", 32'(rx_full), 32'd1);
    check("rxj_level_8",  32'(rx_level), 32'd8);

    // Join TX: capacity 8
    join_mode = 2'b01; err_clr = 1'b1; step();
    for (int k = 1; k <= 7; k++) tx_wr(32'(k));
    check("txj_full_at7", 32'(tx_full), 32'd0);
    tx_wr(32'd8);
    check("txj_full_at8", 32'(tx_full), 32'd1);
    check("txj_level_8",  32'(tx_level), 32'd8);
    rx_push = 1'b1; rx_din = 32'hEE; step();
    check("txj_rx_over",  32'(rx_over), 32'd1);
    check("txj_rx_fe",    {rx_full, rx_empty}, 32'b11);
    for (int k = 1; k <= 8; k++) begin
      check("txj_pop_order", tx_dout, 32'(k));
      tx_pull = 1'b1; step();
    end

    // Explicit flush beats a push; flags survive
    tx_wr(32'h5); tx_wr(32'h6);
    flush = 1'b1; tx_push = 1'b1; tx_din = 32'h9; step();
    check("flush_level", 32'(tx_level), 32'd0);
    check("flush_keeps_flag", 32'(rx_over), 32'd1);

    // Asynchronous reset between edges
    join_mode = 2'b00;
    tx_wr(32'h77);
    tx_wr(32'h78);
    #3 reset = 1'b1;
    #1;
    check("arst_tx_level", 32'(tx_level), 32'd0);
    check("arst_empty",    {tx_empty, rx_empty}, 32'b11);
    check("arst_dout",     tx_dout, 32'd0);
    check("arst_flags",    {tx_over, rx_over, tx_under, rx_under}, 32'd0);
    #1 reset = 1'b0;
    step();
    check("post_rst_tx_full", 32'(tx_full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
